// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage MIPS core: latch enables/flushes,
// load-use and cache-wait stalls, branch/jump redirects, halt drain and perf counters.
module hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_mem,
  input  logic             dmemWEN_mem,
  input  logic             memRead_ex,
  input  logic [4:0]       Rd_ex,
  input  logic [4:0]       Rs_dec,
  input  logic [4:0]       Rt_dec,
  input  logic             useRt_dec,
  input  logic             branchTaken_ex,
  input  logic             jump_dec,
  input  logic             halt_mem,
  output logic             pcEN,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DWAIT   = 2'd1,
    HALTING = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t state, state_next;
  logic   mem_wait;
  logic   load_use;
  logic   stall_inc;
  logic   flush_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}}))
      return v + CNT_W'(1);
    return v;
  endfunction

  assign mem_wait = (dmemREN_mem | dmemWEN_mem) & ~dhit;

  // $zero never carries a real dependency, so it cannot create a hazard
  assign load_use = memRead_ex && (Rd_ex != 5'd0) &&
                    ((Rd_ex == Rs_dec) || (useRt_dec && (Rd_ex == Rt_dec)));

  always_comb begin
    state_next  = state;
    pcEN        = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    halt        = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (nRST) begin
      case (state)
        RUN, DWAIT: begin
          if ((state == RUN && mem_wait) || (state == DWAIT && !dhit)) begin
            state_next = DWAIT;
          end else begin
            state_next = RUN;
            pcEN       = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            if (halt_mem) begin
              pcEN        = 1'b0;
              ifid_flush  = 1'b1;
              idex_flush  = 1'b1;
              exmem_flush = 1'b1;
              state_next  = HALTING;
            end else if (branchTaken_ex) begin
              // Redirect wins over any stall: the DEC slot is squashed anyway
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
              flush_inc  = 1'b1;
            end else if (load_use) begin
              pcEN       = 1'b0;
              ifid_en    = 1'b0;
              idex_flush = 1'b1;
            end else if (jump_dec) begin
              pcEN       = ihit;
              ifid_flush = 1'b1;
            end else if (!ihit) begin
              pcEN       = 1'b0;
              ifid_flush = 1'b1;
            end
          end
          stall_inc = ~pcEN;
        end
        HALTING: begin
          memwb_en   = 1'b1;
          state_next = HALTED;
        end
        HALTED: begin
          halt = 1'b1;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      stall_cnt <= sat_inc(stall_cnt, stall_inc);
      flush_cnt <= sat_inc(flush_cnt, flush_inc);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios plus randomized traffic checked
// against a rule-level reference model of the pipeline controls and counters.
module tb_hazard_controller;
  localparam int CNT_W = 4;
  localparam int SAT   = 15;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit, dmemREN_mem, dmemWEN_mem, memRead_ex;
  logic [4:0]       Rd_ex, Rs_dec, Rt_dec;
  logic             useRt_dec, branchTaken_ex, jump_dec, halt_mem;
  logic             pcEN, ifid_en, ifid_flush, idex_en, idex_flush;
  logic             exmem_en, exmem_flush, memwb_en, halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [8:0]       got_ctl;

  int compared   = 0;
  int mismatched = 0;
  int m_mode;   // 0 running, 1 waiting on data, 2 draining, 3 halted
  int m_stall;
  int m_flush;

  hazard_controller #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem), .memRead_ex(memRead_ex),
    .Rd_ex(Rd_ex), .Rs_dec(Rs_dec), .Rt_dec(Rt_dec), .useRt_dec(useRt_dec),
    .branchTaken_ex(branchTaken_ex), .jump_dec(jump_dec), .halt_mem(halt_mem),
    .pcEN(pcEN), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  assign got_ctl = {pcEN, ifid_en, ifid_flush, idex_en, idex_flush,
                    exmem_en, exmem_flush, memwb_en, halt};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: expected control word, next mode and counter events for current inputs
  function automatic void model(output logic [8:0] ctl, output int nxt,
                                output bit st, output bit fl);
    bit pc, ie, ifl, de, dfl, xe, xfl, we, h, lu, waiting;
    {pc, ie, ifl, de, dfl, xe, xfl, we, h} = 9'b0;
    nxt = m_mode;
    st  = 0;
    fl  = 0;
    lu  = memRead_ex && Rd_ex != 0 && (Rd_ex == Rs_dec || (useRt_dec && Rd_ex == Rt_dec));
    if (m_mode == 3) begin
      h = 1;
    end else if (m_mode == 2) begin
      we  = 1;
      nxt = 3;
    end else begin
      waiting = (m_mode == 0) ? ((dmemREN_mem || dmemWEN_mem) && !dhit) : !dhit;
      if (waiting) begin
        nxt = 1;
      end else begin
        nxt = 0;
        {pc, ie, de, xe, we} = 5'b11111;
        if (halt_mem) begin
          pc = 0; ifl = 1; dfl = 1; xfl = 1; nxt = 2;
        end else if (branchTaken_ex) begin
          ifl = 1; dfl = 1; fl = 1;
        end else if (lu) begin
          pc = 0; ie = 0; dfl = 1;
        end else if (jump_dec) begin
          pc = ihit; ifl = 1;
        end else if (!ihit) begin
          pc = 0; ifl = 1;
        end
      end
      st = !pc;
    end
    ctl = {pc, ie, ifl, de, dfl, xe, xfl, we, h};
  endfunction

  task automatic cyc(input string tag);
    logic [8:0] e;
    int nxt;
    bit st, fl;
    @(negedge CLK);
    model(e, nxt, st, fl);
    check({tag, ".ctl"}, 32'(got_ctl), 32'(e));
    check({tag, ".stall"}, 32'(stall_cnt), m_stall);
    check({tag, ".flush"}, 32'(flush_cnt), m_flush);
    @(posedge CLK);
    m_mode = nxt;
    if (st && m_stall < SAT) m_stall++;
    if (fl && m_flush < SAT) m_flush++;
    #1;
  endtask

  task automatic idle();
    ihit = 1; dhit = 1; dmemREN_mem = 0; dmemWEN_mem = 0; memRead_ex = 0;
    Rd_ex = 0; Rs_dec = 0; Rt_dec = 0; useRt_dec = 0;
    branchTaken_ex = 0; jump_dec = 0; halt_mem = 0;
  endtask

  task automatic do_reset(input string tag);
    nRST = 0;
    #2;
    check({tag, ".ctl"}, 32'(got_ctl), 32'd0);
    check({tag, ".stall"}, 32'(stall_cnt), 32'd0);
    check({tag, ".flush"}, 32'(flush_cnt), 32'd0);
    m_mode = 0; m_stall = 0; m_flush = 0;
    @(posedge CLK);
    #1 nRST = 1;
  endtask

  task automatic rand_inputs();
    ihit           = ($urandom_range(0, 9) < 8);
    dhit           = ($urandom_range(0, 9) < 6);
    dmemREN_mem    = ($urandom_range(0, 9) < 2);
    dmemWEN_mem    = ($urandom_range(0, 9) < 1);
    memRead_ex     = ($urandom_range(0, 9) < 4);
    Rd_ex          = 5'($urandom_range(0, 3));
    Rs_dec         = 5'($urandom_range(0, 3));
    Rt_dec         = 5'($urandom_range(0, 3));
    useRt_dec      = 1'($urandom_range(0, 1));
    branchTaken_ex = ($urandom_range(0, 9) < 2);
    jump_dec       = ($urandom_range(0, 9) < 2);
    halt_mem       = 0;
  endtask

  initial begin
    idle();
    nRST = 0;
    #3;
    do_reset("rst0");

    // Load-use: exactly one bubble
    memRead_ex = 1; Rd_ex = 5; Rs_dec = 5;
    cyc("lu");
    memRead_ex = 0;
    cyc("lu_next");
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // $zero and unused-rt exemptions
    do_reset("rst1");
    memRead_ex = 1; Rd_ex = 0; Rs_dec = 0;
    cyc("zero_rs");
    Rd_ex = 7; Rt_dec = 7; Rs_dec = 1; useRt_dec = 0;
    cyc("no_rt");
    check("zero_stall_cnt", 32'(stall_cnt), 32'd0);
    idle();

    // Data wait three cycles then hit
    do_reset("rst2");
    dmemREN_mem = 1; dhit = 0;
    for (int i = 0; i < 3; i++) cyc("dwait");
    dhit = 1;
    cyc("dwait_hit");
    dmemREN_mem = 0;
    cyc("dwait_after");
    check("dwait_stall_cnt", 32'(stall_cnt), 32'd3);

    // Branch beats load-use and fetch miss
    do_reset("rst3");
    branchTaken_ex = 1; memRead_ex = 1; Rd_ex = 5; Rs_dec = 5; ihit = 0;
    cyc("br_prio");
    idle();
    cyc("br_after");
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    check("br_stall_cnt", 32'(stall_cnt), 32'd0);
    jump_dec = 1; ihit = 0;
    cyc("jump_miss");
    idle();

    // Reset while waiting on data returns straight to RUN
    dmemWEN_mem = 1; dhit = 0;
    cyc("dw_pre");
    cyc("dw_hold");
    do_reset("rst_dwait");
    idle();
    cyc("dw_post_rst");

    // Counter saturation
    ihit = 0;
    for (int i = 0; i < 20; i++) cyc("sat");
    check("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    idle();
    branchTaken_ex = 1;
    for (int i = 0; i < 18; i++) cyc("sat_br");
    check("sat_flush_cnt", 32'(flush_cnt), 32'd15);
    idle();

    // Randomized traffic with occasional resets
    for (int blk = 0; blk < 4; blk++) begin
      do_reset("rst_rand");
      for (int i = 0; i < 100; i++) begin
        rand_inputs();
        cyc("rand");
      end
    end

    // Halt drain then sticky halt
    do_reset("rst4");
    idle();
    halt_mem = 1;
    cyc("halt1");
    halt_mem = 0;
    cyc("halt2");
    for (int i = 0; i < 6; i++) begin
      rand_inputs();
      halt_mem = 1'($urandom_range(0, 1));
      cyc("halted");
    end
    check("halt_sticky", 32'(halt), 32'd1);
    do_reset("rst_halt");
    idle();
    cyc("post_halt");
    check("halt_cleared", 32'(halt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core. It drives the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latch enables and flushes.
- Detects load-use hazards that the forwarding unit cannot cover, taken-branch and jump redirects, cache wait states, and halt drain.
- Keeps saturating stall and flush counters for performance debug.
- Sits beside forwarding_unit. Register fields use cpu_types_pkg regbits_t (5 bits).

Parameters:
CNT_W, 16, width of the stall_cnt and flush_cnt performance counters

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
ihit  input  1  instruction fetch valid this cycle
dhit  input  1  data access in MEM completes this cycle
dmemREN_mem  input  1  load in MEM stage
dmemWEN_mem  input  1  store in MEM stage
memRead_ex  input  1  instruction in EX is a load
Rd_ex  input  5  destination register of EX instruction
Rs_dec  input  5  rs of DEC instruction
Rt_dec  input  5  rt of DEC instruction
useRt_dec  input  1  DEC instruction reads rt as a source
branchTaken_ex  input  1  branch in EX resolved taken
jump_dec  input  1  j/jal/jr decoded in DEC
halt_mem  input  1  halt instruction in MEM
pcEN  output  1  PC register update enable
ifid_en  output  1  IF/ID latch enable
ifid_flush  output  1  IF/ID load bubble
idex_en  output  1  ID/EX latch enable
idex_flush  output  1  ID/EX load bubble
exmem_en  output  1  EX/MEM latch enable
exmem_flush  output  1  EX/MEM load bubble
memwb_en  output  1  MEM/WB latch enable
halt  output  1  core halted, sticky
stall_cnt  output  CNT_W  cycles with pcEN=0 in RUN or DWAIT
flush_cnt  output  CNT_W  taken-branch flush events

Behaviour:
- Clock, reset and output timing
  - One clock domain.
  - While nRST=0 (asynchronous): state=RUN, counters=0, halt=0, all enables and flushes 0.
  - Controls are combinational from state and inputs. State and counters are registered.
- State RUN. Exactly the first matching rule applies; otherwise all enables are 1 and all flushes are 0.
  1. Data wait: (dmemREN_mem|dmemWEN_mem)&!dhit
     - All enables 0; next state DWAIT.
  2. Halt: halt_mem
     - pcEN=0; ifid/idex/exmem flush=1 with enables 1; memwb_en=1 so the older instruction retires.
     - Next state HALTING.
  3. Branch: branchTaken_ex
     - pcEN=1 (target loaded); ifid_flush=1; idex_flush=1; others advance.
     - flush_cnt+1.
  4. Load-use: memRead_ex & Rd_ex!=0 & (Rd_ex==Rs_dec | (useRt_dec & Rd_ex==Rt_dec))
     - pcEN=0, ifid_en=0, idex_flush=1; others advance.
     - Exactly one bubble. The next cycle re-evaluates, with the load now in MEM, covered by forwarding.
  5. Jump: jump_dec
     - ifid_flush=1; others advance.
  6. Fetch miss: !ihit
     - pcEN=0; ifid_flush=1; others advance.
- State DWAIT
  - All enables 0 while dhit=0.
  - In the cycle dhit=1: controls evaluated exactly as in RUN with rule 1 disabled; next state RUN.
- State HALTING
  - memwb_en=1, all other enables 0, flushes 0.
  - Next state HALTED unconditionally.
- State HALTED
  - halt=1, all enables 0, flushes 0.
  - Leaves only on reset. All inputs ignored.
- Simultaneous events
  - Branch with load-use: branch wins; the DEC instruction is squashed and there is no stall.
  - Branch with !ihit: pcEN=1, and the fetched slot is flushed anyway.
  - Jump with !ihit: pcEN=0, ifid_flush=1.
- Counters
  - stall_cnt increments when pcEN=0 in RUN or DWAIT. HALTING and HALTED excluded.
  - Both counters saturate at all-ones and do not wrap.
- Reset mid-operation
  - Reset during DWAIT or HALTING returns to RUN immediately.
  - Counters cleared; no pending state is retained.

Test Plan:
- Load-use: memRead_ex=1, Rd_ex=5, Rs_dec=5, all hits 1 -> one cycle pcEN=0, ifid_en=0, idex_flush=1, stall_cnt=1. Next cycle (memRead_ex=0) all enables 1.
- $zero exemption: Rd_ex=0=Rs_dec; also Rd_ex=7=Rt_dec with useRt_dec=0 -> no stall, stall_cnt stays 0.
- Data wait: dmemREN_mem=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles all enables 0 (state DWAIT); 4th cycle all enables 1; then RUN; stall_cnt=3.
- Branch priority: branchTaken_ex=1 with load-use hazard and ihit=0 -> pcEN=1, ifid_flush=1, idex_flush=1, flush_cnt=1, stall_cnt unchanged.
- Halt: halt_mem=1 -> cycle 1 pcEN=0, exmem_flush=1, memwb_en=1; cycle 2 memwb_en=1 only; cycle 3 onward halt=1 with any inputs. Pulse nRST=0 -> halt=0, counters 0, RUN.
- Saturation with CNT_W=4: hold ihit=0 for 20 cycles -> stall_cnt reaches 15 and holds.
